// File: rtl/sdram_avalon_arbiter.sv
// Two-master Avalon-MM burst arbiter in front of one SDRAM controller user port; grant held per full transaction.
// Round-robin by default; define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (m0 wins).
module sdram_avalon_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 22,
  parameter int BURST_W = 9
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [BURST_W-1:0]    m0_burstcount,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [BURST_W-1:0]    m1_burstcount,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  output logic [BURST_W-1:0]    s_burstcount,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_readdatavalid,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {IDLE, WRITE, READ_CMD, READ_DATA} state_t;

  state_t               state;
  logic [BURST_W-1:0]   beats;
  logic                 req0, req1, pick1, sel_read, own1, cmd_phase;
  logic [BURST_W-1:0]   sel_bc;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  // last1 remembers who was served last; starts at m1 so m0 wins the first tie
  logic last1;
  assign pick1 = req1 & (~req0 | ~last1);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      last1 <= 1'b1;
    end else if (state == IDLE && (req0 | req1)) begin
      last1 <= pick1;
    end
  end
`endif

  assign sel_read = pick1 ? m1_read : m0_read;
  assign sel_bc   = pick1 ? m1_burstcount : m0_burstcount;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
      grant <= 2'b00;
      beats <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant <= pick1 ? 2'b10 : 2'b01;
            beats <= (sel_bc == '0) ? BURST_W'(1) : sel_bc;
            state <= sel_read ? READ_CMD : WRITE;
          end
        end
        WRITE: begin
          if (s_write && !s_waitrequest) begin
            if (beats != '0) beats <= beats - 1'b1;
            if (beats <= BURST_W'(1)) begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        READ_CMD: begin
          if (s_read && !s_waitrequest) state <= READ_DATA;
        end
        READ_DATA: begin
          if (s_readdatavalid) begin
            if (beats != '0) beats <= beats - 1'b1;
            if (beats <= BURST_W'(1)) begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Owner's buses pass straight through; strobes gated by phase so nothing leaks outside its window
  assign own1         = grant[1];
  assign cmd_phase    = (state == WRITE) || (state == READ_CMD);
  assign s_address    = own1 ? m1_address    : m0_address;
  assign s_writedata  = own1 ? m1_writedata  : m0_writedata;
  assign s_byteenable = own1 ? m1_byteenable : m0_byteenable;
  assign s_burstcount = own1 ? m1_burstcount : m0_burstcount;
  assign s_write      = (state == WRITE)    && (own1 ? m1_write : m0_write);
  assign s_read       = (state == READ_CMD) && (own1 ? m1_read  : m0_read);

  assign m0_waitrequest   = ~(grant[0] & cmd_phase & ~s_waitrequest);
  assign m1_waitrequest   = ~(grant[1] & cmd_phase & ~s_waitrequest);
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = s_readdatavalid && (state == READ_DATA) && grant[0];
  assign m1_readdatavalid = s_readdatavalid && (state == READ_DATA) && grant[1];

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Directed testbench for sdram_avalon_arbiter; honours SDRAM_ARB_FIXED_PRIO_EN for expected grant order.
module tb_sdram_avalon_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic [8:0]  m0_burstcount, m1_burstcount, s_burstcount;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [15:0] m0_readdata, m1_readdata, s_readdata;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [1:0]  grant;

  int errors = 0;
  int checks = 0;
  int cnt0, cnt1;
  logic [1:0] exp_grant [4];

  always #5 clk = ~clk;

  sdram_avalon_arbiter dut (
    .clk_clk(clk), .reset_reset(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_burstcount(s_burstcount),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    rst = 1'b1;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 2'b11; m0_burstcount = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 2'b11; m1_burstcount = '0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;

    // reset state, with a stray readdatavalid present
    repeat (2) @(posedge clk);
    @(negedge clk); s_readdatavalid = 1; #1;
    check("rst_grant", grant, 2'b00);
    check("rst_m0_wait", m0_waitrequest, 1);
    check("rst_m1_wait", m1_waitrequest, 1);
    check("rst_s_read", s_read, 0);
    check("rst_s_write", s_write, 0);
    check("rst_m0_rdv", m0_readdatavalid, 0);
    check("rst_m1_rdv", m1_readdatavalid, 0);
    s_readdatavalid = 0; rst = 0;

    // m0 write burst of 4, no backpressure
    @(negedge clk);
    m0_write = 1; m0_burstcount = 9'd4; m0_address = 22'h123; m0_writedata = 16'hA000; #1;
    check("wr_pre_grant", grant, 2'b00);
    check("wr_pre_wait", m0_waitrequest, 1);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); m0_writedata = 16'hA000 + 16'(i); #1;
      check("wr_grant", grant, 2'b01);
      check("wr_s_write", s_write, 1);
      check("wr_data", s_writedata, 16'hA000 + 16'(i));
      check("wr_m0_wait", m0_waitrequest, 0);
      check("wr_m1_wait", m1_waitrequest, 1);
      @(posedge clk);
    end
    @(negedge clk); m0_write = 0; #1;
    check("wr_done_grant", grant, 2'b00);
    check("wr_s_addr_idle", s_write, 0);

    // m1 read burst of 8 with 3 cycles of controller backpressure
    m1_read = 1; m1_burstcount = 9'd8; m1_address = 22'h3ABCD; s_waitrequest = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rd_hold_s_read", s_read, 1);
      check("rd_hold_grant", grant, 2'b10);
      check("rd_hold_m1_wait", m1_waitrequest, 1);
      check("rd_hold_addr", s_address, 22'h3ABCD);
      @(posedge clk);
    end
    @(negedge clk); s_waitrequest = 0; #1;
    check("rd_acc_s_read", s_read, 1);
    check("rd_acc_m1_wait", m1_waitrequest, 0);
    check("rd_acc_m0_wait", m0_waitrequest, 1);
    @(posedge clk);
    @(negedge clk); m1_read = 0; #1;
    check("rd_data_s_read", s_read, 0);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      s_readdatavalid = 1; s_readdata = 16'hD000 + 16'(i); #1;
      if (m1_readdatavalid) cnt1++;
      if (m0_readdatavalid) cnt0++;
      check("rd_m1_data", m1_readdata, 16'hD000 + 16'(i));
      @(posedge clk);
      @(negedge clk);
    end
    check("rd_m1_count", cnt1, 8);
    check("rd_m0_count", cnt0, 0);
    #1;
    check("rd_done_grant", grant, 2'b00);
    check("rd_stray_m1_rdv", m1_readdatavalid, 0);
    s_readdatavalid = 0;

    // both masters request continuously, burst 1 (m1 uses burstcount 0)
    m0_write = 1; m0_burstcount = 9'd1; m1_write = 1; m1_burstcount = 9'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk); #1;
      check("arb_grant", grant, exp_grant[i]);
      check("arb_s_write", s_write, 1);
      @(posedge clk);
      @(negedge clk); #1;
      check("arb_idle_gap", grant, 2'b00);
    end
    m0_write = 0; m1_write = 0;

    // reset in the middle of an 8-beat m0 read
    m0_read = 1; m0_burstcount = 9'd8; m0_address = 22'h00042;
    @(posedge clk);
    @(negedge clk); #1;
    check("mrst_s_read", s_read, 1);
    @(posedge clk);
    @(negedge clk); m0_read = 0;
    for (int i = 0; i < 2; i++) begin
      s_readdatavalid = 1; #1;
      check("mrst_m0_rdv", m0_readdatavalid, 1);
      @(posedge clk);
      @(negedge clk);
    end
    s_readdatavalid = 0;
    #2 rst = 1; #1;
    check("mrst_grant", grant, 2'b00);
    check("mrst_m0_wait", m0_waitrequest, 1);
    check("mrst_s_read", s_read, 0);
    @(negedge clk); rst = 0;
    s_readdatavalid = 1; #1;
    check("mrst_stray_m0", m0_readdatavalid, 0);
    check("mrst_stray_m1", m1_readdatavalid, 0);
    @(posedge clk);
    @(negedge clk); #1;
    check("mrst_stays_idle", grant, 2'b00);
    s_readdatavalid = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
